// File: rtl/com_sort_ctrl.sv
// Four-entry descending sort controller sharing one greater-than comparator.
// Optional build macro SORT_EARLY_EXIT_EN ends the sort after a pass with no swaps.
module com_sort_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic         busy,
  output logic         done,
  output logic [2:0]   swap_cnt
);

  typedef enum logic {IDLE, SORT} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] r [4];
  logic [W-1:0] r_nxt [4];
  logic [1:0]   pass, pass_nxt;
  logic [1:0]   idx, idx_nxt;
  logic [1:0]   idx_hi;
  logic [2:0]   cnt_nxt;
  logic         done_nxt;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_x;
  logic         last_in_pass;
  logic         finish;

`ifdef SORT_EARLY_EXIT_EN
  logic pass_swapped, pass_swapped_nxt;
`endif

  // Single shared comparator: ai is the upper neighbour, bi the current slot
  assign idx_hi       = idx + 2'd1;
  assign cmp_a        = r[idx_hi];
  assign cmp_b        = r[idx];
  assign cmp_x        = cmp_a > cmp_b;
  assign last_in_pass = (idx == (2'd2 - pass));

`ifdef SORT_EARLY_EXIT_EN
  assign finish = ((pass == 2'd2) && (idx == 2'd0)) ||
                  (last_in_pass && !pass_swapped && !cmp_x);
`else
  assign finish = (pass == 2'd2) && (idx == 2'd0);
`endif

  assign busy     = (state == SORT);
  assign q0       = r[0];
  assign q1       = r[1];
  assign q2       = r[2];
  assign q3       = r[3];

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    pass_nxt  = pass;
    idx_nxt   = idx;
    cnt_nxt   = swap_cnt;
    done_nxt  = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    pass_swapped_nxt = pass_swapped;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          r_nxt[0]  = d0;
          r_nxt[1]  = d1;
          r_nxt[2]  = d2;
          r_nxt[3]  = d3;
          pass_nxt  = 2'd0;
          idx_nxt   = 2'd0;
          cnt_nxt   = 3'd0;
          state_nxt = SORT;
`ifdef SORT_EARLY_EXIT_EN
          pass_swapped_nxt = 1'b0;
`endif
        end
      end
      SORT: begin
        // Strict greater-than: equal neighbours stay in place
        if (cmp_x) begin
          r_nxt[idx]    = cmp_a;
          r_nxt[idx_hi] = cmp_b;
          cnt_nxt       = swap_cnt + 3'd1;
        end
        if (last_in_pass) begin
          pass_nxt = pass + 2'd1;
          idx_nxt  = 2'd0;
        end else begin
          idx_nxt  = idx + 2'd1;
        end
`ifdef SORT_EARLY_EXIT_EN
        pass_swapped_nxt = last_in_pass ? 1'b0 : (pass_swapped | cmp_x);
`endif
        if (finish) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int i = 0; i < 4; i++) r[i] <= '0;
      pass     <= 2'd0;
      idx      <= 2'd0;
      swap_cnt <= 3'd0;
      done     <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      pass_swapped <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      for (int i = 0; i < 4; i++) r[i] <= r_nxt[i];
      pass     <= pass_nxt;
      idx      <= idx_nxt;
      swap_cnt <= cnt_nxt;
      done     <= done_nxt;
`ifdef SORT_EARLY_EXIT_EN
      pass_swapped <= pass_swapped_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_com_sort_ctrl.sv
// Self-checking bench for com_sort_ctrl: directed cases plus random sorts,
// compared against a reference built from plain sorting and inversion counting.
module tb_com_sort_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] q0, q1, q2, q3;
  logic       busy;
  logic       done;
  logic [2:0] swap_cnt;

  int n_checks;
  int n_fail;

  logic [3:0] exp_q [4];
  int         exp_cnt;
  int         exp_lat;

  com_sort_ctrl #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .q0       (q0),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: descending order by sorting, swap count as the number of
  // strictly ascending pairs (each bubble swap removes exactly one).
  task automatic computeModel(input logic [3:0] v0, v1, v2, v3);
    int vals [4];
    int qv [$];
    vals = '{int'(v0), int'(v1), int'(v2), int'(v3)};
    qv = {};
    for (int i = 0; i < 4; i++) qv.push_back(vals[i]);
    qv.rsort();
    for (int i = 0; i < 4; i++) exp_q[i] = 4'(qv[i]);
    exp_cnt = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (vals[i] < vals[j]) exp_cnt++;
    exp_lat = 6;
`ifdef SORT_EARLY_EXIT_EN
    begin
      int arr [4];
      int t;
      bit sw;
      arr = vals;
      exp_lat = 0;
      for (int p = 0; p < 3; p++) begin
        sw = 1'b0;
        for (int i = 0; i <= 2 - p; i++) begin
          if (arr[i+1] > arr[i]) begin
            t = arr[i]; arr[i] = arr[i+1]; arr[i+1] = t; sw = 1'b1;
          end
        end
        exp_lat += 3 - p;
        if (!sw) break;
      end
    end
`endif
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_q0"}, q0, 0);
    checkOutput({tag, "_q1"}, q1, 0);
    checkOutput({tag, "_q2"}, q2, 0);
    checkOutput({tag, "_q3"}, q3, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_cnt"}, swap_cnt, 0);
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, "_q0"}, q0, exp_q[0]);
    checkOutput({tag, "_q1"}, q1, exp_q[1]);
    checkOutput({tag, "_q2"}, q2, exp_q[2]);
    checkOutput({tag, "_q3"}, q3, exp_q[3]);
    checkOutput({tag, "_cnt"}, swap_cnt, exp_cnt);
  endtask

  // Called away from an edge; launches a sort and waits for its done pulse.
  // With hold=1 start stays high, and the caller is left in the done cycle.
  task automatic applyStimulus(input string tag, input logic [3:0] v0, v1, v2, v3,
                               input bit hold);
    int n;
    computeModel(v0, v1, v2, v3);
    d0 = v0; d1 = v1; d2 = v2; d3 = v3;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    checkOutput({tag, "_busy_e0"}, busy, 1);
    checkOutput({tag, "_done_e0"}, done, 0);
    n = 0;
    while (!done && n < 20) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      @(posedge clk); #1;
      n++;
      if (!done) checkOutput({tag, "_busy_mid"}, busy, 1);
    end
    checkOutput({tag, "_latency"}, n, exp_lat);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_end"}, busy, 0);
    checkResult(tag);
    if (!hold) begin
      @(posedge clk); #1;
      checkOutput({tag, "_done_clr"}, done, 0);
      checkOutput({tag, "_busy_idle"}, busy, 0);
      checkResult({tag, "_stable"});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
    #2;
    checkZero("reset");
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      @(posedge clk); #1;
      checkZero("reset_hold");
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      @(posedge clk); #1;
      checkZero("idle_nostart");
    end

    applyStimulus("mixed", 4'd3, 4'd9, 4'd1, 4'd7, 1'b0);
    applyStimulus("sorted", 4'hF, 4'hA, 4'h5, 4'h0, 1'b0);
    applyStimulus("reverse", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0);

    // Start held through the sort, then a new sort accepted in the done cycle
    applyStimulus("equal_hold", 4'd5, 4'd5, 4'd5, 4'd5, 1'b1);
    applyStimulus("back2back", 4'd2, 4'd8, 4'd2, 4'd1, 1'b0);

    // Reset between E2 and E3 of a sort in progress
    d0 = 4'd7; d1 = 4'd3; d2 = 4'd9; d3 = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("midrst_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkZero("midrst_release");
    applyStimulus("after_rst", 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);

    for (int k = 0; k < 16; k++) begin
      applyStimulus($sformatf("rand%0d", k), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
